// File: rtl/vip_box_pkg.sv
// Shared box format for the target-box overlay: detector field layout, packed view and colours.
// Used by vip_target_box_overlay and vip_box_hit (optional VIP_BOX_CROSSHAIR_EN lives there).
package vip_box_pkg;

   localparam int BOX_W       = 43;
   localparam int BOX_FLAG    = 42;
   localparam int BOX_YMAX_HI = 41;
   localparam int BOX_YMAX_LO = 32;
   localparam int BOX_XMAX_HI = 31;
   localparam int BOX_XMAX_LO = 21;
   localparam int BOX_YMIN_HI = 20;
   localparam int BOX_YMIN_LO = 11;
   localparam int BOX_XMIN_HI = 10;
   localparam int BOX_XMIN_LO = 0;

   localparam logic [23:0] COLOR1_DEF = 24'hFF0000;
   localparam logic [23:0] COLOR2_DEF = 24'h00FF00;

   typedef struct packed {
      logic        flag;
      logic [9:0]  ymax;
      logic [10:0] xmax;
      logic [9:0]  ymin;
      logic [10:0] xmin;
   } box_t;

   function automatic box_t box_unpack(input logic [BOX_W-1:0] v);
      box_t b;
      b.flag = v[BOX_FLAG];
      b.ymax = v[BOX_YMAX_HI:BOX_YMAX_LO];
      b.xmax = v[BOX_XMAX_HI:BOX_XMAX_LO];
      b.ymin = v[BOX_YMIN_HI:BOX_YMIN_LO];
      b.xmin = v[BOX_XMIN_HI:BOX_XMIN_LO];
      return b;
   endfunction

endpackage

// File: rtl/vip_box_hit.sv
// Border hit test for one shadowed box against the stage-1 pixel coordinate, registered once.
// With VIP_BOX_CROSSHAIR_EN defined it also flags a 1-pixel crosshair through the box centre.
module vip_box_hit
   import vip_box_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  box_t        box,
   input  logic [10:0] x,
   input  logic [9:0]  y,
   input  logic [3:0]  thick,
   output logic        hit
`ifdef VIP_BOX_CROSSHAIR_EN
   ,
   output logic        hit_cross
`endif
);

   // Everything widened to 12 bits so xmax+T etc. cannot wrap; no subtraction is needed.
   logic [11:0] x12, y12, xmin12, xmax12, ymin12, ymax12, t12;
   logic        in_box, on_edge;

   assign x12    = {1'b0, x};
   assign y12    = {2'b0, y};
   assign xmin12 = {1'b0, box.xmin};
   assign xmax12 = {1'b0, box.xmax};
   assign ymin12 = {2'b0, box.ymin};
   assign ymax12 = {2'b0, box.ymax};
   assign t12    = {8'b0, thick};

   assign in_box  = box.flag & (xmin12 <= x12) & (x12 <= xmax12)
                             & (ymin12 <= y12) & (y12 <= ymax12);
   assign on_edge = (x12 < xmin12 + t12) | (x12 + t12 > xmax12)
                  | (y12 < ymin12 + t12) | (y12 + t12 > ymax12);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) hit <= 1'b0;
      else        hit <= in_box & on_edge;
   end

`ifdef VIP_BOX_CROSSHAIR_EN
   logic [10:0] cx;
   logic [9:0]  cy;

   // The shadow box only changes at frame start, so the centre settles one cycle after the load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cx        <= '0;
         cy        <= '0;
         hit_cross <= 1'b0;
      end else begin
         cx        <= 11'((xmin12 + xmax12) >> 1);
         cy        <= 10'((ymin12 + ymax12) >> 1);
         hit_cross <= box.flag & (((x == cx) & (ymin12 <= y12) & (y12 <= ymax12))
                                | ((y == cy) & (xmin12 <= x12) & (x12 <= xmax12)));
      end
   end
`endif

endmodule

// File: rtl/vip_target_box_overlay.sv
// Draws the two detector boxes onto the RGB stream with a fixed 2-cycle pipeline.
// Define VIP_BOX_CROSSHAIR_EN to add a centre crosshair per box.
module vip_target_box_overlay
   import vip_box_pkg::*;
#(
   parameter logic [10:0]       IMG_HDISP = 11'd1280,
   parameter logic [9:0]        IMG_VDISP = 10'd720,
   parameter int                DATA_W    = 24,
   parameter int                BOX_THICK = 2,
   parameter logic [DATA_W-1:0] COLOR1    = COLOR1_DEF,
   parameter logic [DATA_W-1:0] COLOR2    = COLOR2_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              per_frame_vsync,
   input  logic              per_frame_href,
   input  logic              per_frame_clken,
   input  logic [DATA_W-1:0] per_img_data,
   input  logic [BOX_W-1:0]  target_pos_in1,
   input  logic [BOX_W-1:0]  target_pos_in2,
   input  logic              overlay_en,
   output logic              post_frame_vsync,
   output logic              post_frame_href,
   output logic              post_frame_clken,
   output logic [DATA_W-1:0] post_img_data
);

   if (IMG_HDISP == 11'd0 || IMG_VDISP == 10'd0) begin : g_bad_geometry
      $error("vip_target_box_overlay: image geometry must be non-zero");
   end

   logic              vs_prev, vs_rise;
   box_t              box_sh1, box_sh2;
   logic [10:0]       x_cnt, s1_x;
   logic [9:0]        y_cnt, s1_y;
   logic              s1_vs, s1_hs, s1_ck, s1_en;
   logic              s2_vs, s2_hs, s2_ck, s2_en;
   logic [DATA_W-1:0] s1_data, s2_data;
   logic              hit1, hit2, draw1, draw2;

   assign vs_rise = per_frame_vsync & ~vs_prev;

   // vs_prev resets high so releasing reset inside a frame is not mistaken for a frame start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vs_prev <= 1'b1;
         box_sh1 <= '0;
         box_sh2 <= '0;
      end else begin
         vs_prev <= per_frame_vsync;
         if (vs_rise) begin
            box_sh1 <= box_unpack(target_pos_in1);
            box_sh2 <= box_unpack(target_pos_in2);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_cnt <= '0;
         y_cnt <= '0;
      end else if (!per_frame_vsync) begin
         x_cnt <= '0;
         y_cnt <= '0;
      end else begin
         if (!per_frame_href)
            x_cnt <= '0;
         else if (per_frame_clken && x_cnt != 11'h7FF)
            x_cnt <= x_cnt + 11'd1;
         if (s1_hs && !per_frame_href && y_cnt != 10'h3FF)
            y_cnt <= y_cnt + 10'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vs   <= 1'b0;
         s1_hs   <= 1'b0;
         s1_ck   <= 1'b0;
         s1_en   <= 1'b0;
         s1_data <= '0;
         s1_x    <= '0;
         s1_y    <= '0;
         s2_vs   <= 1'b0;
         s2_hs   <= 1'b0;
         s2_ck   <= 1'b0;
         s2_en   <= 1'b0;
         s2_data <= '0;
      end else begin
         s1_vs   <= per_frame_vsync;
         s1_hs   <= per_frame_href;
         s1_ck   <= per_frame_clken;
         s1_en   <= overlay_en;
         s1_data <= per_img_data;
         s1_x    <= x_cnt;
         s1_y    <= y_cnt;
         s2_vs   <= s1_vs;
         s2_hs   <= s1_hs;
         s2_ck   <= s1_ck;
         s2_en   <= s1_en;
         s2_data <= s1_data;
      end
   end

`ifdef VIP_BOX_CROSSHAIR_EN
   logic hit1_c, hit2_c;
   assign draw1 = hit1 | hit1_c;
   assign draw2 = hit2 | hit2_c;
`else
   assign draw1 = hit1;
   assign draw2 = hit2;
`endif

   vip_box_hit u_hit1 (
      .clk      (clk),
      .rst_n    (rst_n),
      .box      (box_sh1),
      .x        (s1_x),
      .y        (s1_y),
      .thick    (4'(BOX_THICK)),
      .hit      (hit1)
`ifdef VIP_BOX_CROSSHAIR_EN
      ,
      .hit_cross(hit1_c)
`endif
   );

   vip_box_hit u_hit2 (
      .clk      (clk),
      .rst_n    (rst_n),
      .box      (box_sh2),
      .x        (s1_x),
      .y        (s1_y),
      .thick    (4'(BOX_THICK)),
      .hit      (hit2)
`ifdef VIP_BOX_CROSSHAIR_EN
      ,
      .hit_cross(hit2_c)
`endif
   );

   assign post_frame_vsync = s2_vs;
   assign post_frame_href  = s2_hs;
   assign post_frame_clken = s2_ck;
   assign post_img_data    = (s2_ck && s2_en && draw1) ? COLOR1 :
                             (s2_ck && s2_en && draw2) ? COLOR2 : s2_data;

endmodule

// File: tb/tb_vip_target_box_overlay.sv
// Scoreboard bench for vip_target_box_overlay: the driver queues expected pixels, a monitor checks them.
module tb_vip_target_box_overlay;

   localparam logic [23:0] RED   = 24'hFF0000;
   localparam logic [23:0] GREEN = 24'h00FF00;
   localparam int          T     = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        per_frame_vsync = 1'b0;
   logic        per_frame_href = 1'b0;
   logic        per_frame_clken = 1'b0;
   logic [23:0] per_img_data = '0;
   logic [42:0] tgt1 = '0;
   logic [42:0] tgt2 = '0;
   logic        en = 1'b0;
   logic        post_frame_vsync, post_frame_href, post_frame_clken;
   logic [23:0] post_img_data;

   always #5 clk = ~clk;

   vip_target_box_overlay dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .per_frame_vsync (per_frame_vsync),
      .per_frame_href  (per_frame_href),
      .per_frame_clken (per_frame_clken),
      .per_img_data    (per_img_data),
      .target_pos_in1  (tgt1),
      .target_pos_in2  (tgt2),
      .overlay_en      (en),
      .post_frame_vsync(post_frame_vsync),
      .post_frame_href (post_frame_href),
      .post_frame_clken(post_frame_clken),
      .post_img_data   (post_img_data)
   );

   typedef struct {int x; int y; logic [23:0] c; bit keep;} spot_t;
   typedef struct {logic [23:0] d; string name;} exp_t;

   spot_t       spots[$];
   exp_t        expq[$];
   logic [42:0] act1 = '0;
   logic [42:0] act2 = '0;
   logic [26:0] hist0 = '0;
   logic [26:0] hist1 = '0;
   int          checks = 0, errors = 0, red_cnt = 0, green_cnt = 0, lat_skip = 2;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h", name, got, want);
      end
   endtask

   function automatic logic [42:0] mk_box(input bit f, input int y1, input int x1,
                                          input int y0, input int x0);
      return {f, 10'(y1), 11'(x1), 10'(y0), 11'(x0)};
   endfunction

   // Border membership expressed as distance from each edge.
   function automatic bit box_hit(input logic [42:0] b, input int x, input int y);
      int x0, y0, x1, y1;
      x0 = int'(b[10:0]);
      y0 = int'(b[20:11]);
      x1 = int'(b[31:21]);
      y1 = int'(b[41:32]);
      if (!b[42]) return 1'b0;
      if (x < x0 || x > x1 || y < y0 || y > y1) return 1'b0;
      return (x - x0 < T) || (x1 - x < T) || (y - y0 < T) || (y1 - y < T);
   endfunction

   function automatic logic [23:0] ref_pix(input int x, input int y, input logic [23:0] d);
      if (!en) return d;
      if (box_hit(act1, x, y)) return RED;
      if (box_hit(act2, x, y)) return GREEN;
      return d;
   endfunction

   function automatic logic [23:0] pat(input int x, input int y);
      return {8'h11, x[7:0], y[7:0]};
   endfunction

   task automatic drive(input logic v, input logic h, input logic c, input logic [23:0] d,
                        input int x = 0, input int y = 0);
      exp_t e;
      @(negedge clk);
      if (lat_skip > 0) lat_skip--;
      else begin
         chk("sync_latency", 64'({post_frame_vsync, post_frame_href, post_frame_clken}),
             64'(hist1[26:24]));
         if (!post_frame_clken) chk("blank_data", 64'(post_img_data), 64'(hist1[23:0]));
      end
      hist1 = hist0;
      hist0 = {v, h, c, d};
      per_frame_vsync = v;
      per_frame_href  = h;
      per_frame_clken = c;
      per_img_data    = d;
      if (c && rst_n) begin
         e.d    = ref_pix(x, y, d);
         e.name = "pixel";
         foreach (spots[i])
            if (spots[i].x == x && spots[i].y == y) begin
               e.d    = spots[i].keep ? d : spots[i].c;
               e.name = $sformatf("spot_%0d_%0d", x, y);
            end
         expq.push_back(e);
      end
   endtask

   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1;
      chk("rst_async_syncs", 64'({post_frame_vsync, post_frame_href, post_frame_clken}), 64'(0));
      chk("rst_async_data", 64'(post_img_data), 64'(0));
      expq.delete();
      act1 = '0;
      act2 = '0;
      lat_skip = 1000;
      repeat (3) drive(1'b1, 1'b0, 1'b0, 24'h0);
      #1 rst_n = 1'b1;
      lat_skip = 2;
   endtask

   task automatic run_frame(input int nl, input int np,
                            input int chg_line = -1, input logic [42:0] chg_val = '0,
                            input int tog_line = -1, input int tog_px = -1,
                            input int rst_line = -1, input int rst_px = -1);
      repeat (3) drive(1'b0, 1'b0, 1'b0, 24'h0);
      act1 = tgt1;
      act2 = tgt2;
      repeat (2) drive(1'b1, 1'b0, 1'b0, 24'h0);
      for (int y = 0; y < nl; y++) begin
         if (y == chg_line) tgt1 = chg_val;
         for (int x = 0; x < np; x++) begin
            if (y == tog_line && x == tog_px) en = ~en;
            drive(1'b1, 1'b1, 1'b1, pat(x, y), x, y);
            if (y == rst_line && x == rst_px) do_reset();
         end
         repeat (4) drive(1'b1, 1'b0, 1'b0, pat(np, y));
      end
      repeat (2) drive(1'b1, 1'b0, 1'b0, 24'h0);
   endtask

   task automatic add_spot(input int x, input int y, input logic [23:0] c, input bit keep);
      spot_t s;
      s.x = x; s.y = y; s.c = c; s.keep = keep;
      spots.push_back(s);
   endtask

   task automatic frame_counts(input string name, input int red, input int green);
      chk({name, "_red"}, 64'(red_cnt), 64'(red));
      chk({name, "_green"}, 64'(green_cnt), 64'(green));
      red_cnt = 0;
      green_cnt = 0;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && post_frame_clken) begin
            if (post_img_data == RED) red_cnt++;
            if (post_img_data == GREEN) green_cnt++;
            if (expq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_pixel got=%0h want=none", post_img_data);
            end else begin
               e = expq.pop_front();
               chk(e.name, 64'(post_img_data), 64'(e.d));
            end
         end
      end
   end

   initial begin : stimulus
      repeat (3) @(negedge clk);
      chk("reset_syncs", 64'({post_frame_vsync, post_frame_href, post_frame_clken}), 64'(0));
      chk("reset_data", 64'(post_img_data), 64'(0));
      rst_n = 1'b1;
      lat_skip = 2;

      // Pass-through, then overlay_en switched on mid-line.
      en   = 1'b0;
      tgt1 = mk_box(1'b1, 5, 15, 0, 0);
      tgt2 = '0;
      add_spot(1, 3, 24'h0, 1'b1);
      add_spot(3, 1, 24'h0, 1'b1);
      add_spot(14, 3, RED, 1'b0);
      add_spot(5, 4, RED, 1'b0);
      run_frame(6, 16, -1, '0, 3, 5);
      frame_counts("toggle", 34, 0);

      // Single box, box 2 disabled.
      spots.delete();
      tgt1 = mk_box(1'b1, 120, 260, 100, 200);
      tgt2 = mk_box(1'b0, 120, 260, 100, 200);
      add_spot(200, 110, RED, 1'b0);
      add_spot(201, 110, RED, 1'b0);
      add_spot(259, 100, RED, 1'b0);
      add_spot(230, 119, RED, 1'b0);
      add_spot(202, 110, 24'h0, 1'b1);
      add_spot(230, 102, 24'h0, 1'b1);
      run_frame(122, 262);
      frame_counts("single", 312, 0);

      // Overlap priority.
      spots.delete();
      tgt1 = mk_box(1'b1, 50, 50, 10, 10);
      tgt2 = mk_box(1'b1, 90, 90, 40, 40);
      add_spot(50, 45, RED, 1'b0);
      add_spot(90, 60, GREEN, 1'b0);
      add_spot(40, 49, RED, 1'b0);
      run_frame(92, 92);
      frame_counts("overlap", 312, 384);

      // Single column at the right edge; inverted box draws nothing.
      spots.delete();
      tgt1 = mk_box(1'b1, 719, 1279, 0, 1279);
      tgt2 = mk_box(1'b1, 719, 200, 0, 300);
      add_spot(1279, 0, RED, 1'b0);
      add_spot(1279, 2, RED, 1'b0);
      add_spot(1278, 1, 24'h0, 1'b1);
      add_spot(250, 1, 24'h0, 1'b1);
      run_frame(3, 1282);
      frame_counts("column", 3, 0);

      // Box input changes at line 300; only the next frame may show it.
      spots.delete();
      tgt1 = mk_box(1'b1, 5, 6, 2, 2);
      tgt2 = '0;
      add_spot(0, 301, 24'h0, 1'b1);
      run_frame(302, 10, 300, mk_box(1'b1, 400, 7, 0, 0));
      frame_counts("shadow_n", 20, 0);
      spots.delete();
      add_spot(0, 301, RED, 1'b0);
      run_frame(302, 10);
      frame_counts("shadow_n1", 1216, 0);

      // Reset inside a frame, then a clean frame.
      spots.delete();
      tgt1 = mk_box(1'b1, 5, 5, 0, 0);
      add_spot(0, 5, 24'h0, 1'b1);
      run_frame(8, 10, -1, '0, -1, -1, 4, 3);
      frame_counts("reset_frame", 22, 0);
      spots.delete();
      add_spot(0, 5, RED, 1'b0);
      run_frame(8, 10);
      frame_counts("after_reset", 32, 0);

      repeat (4) drive(1'b0, 1'b0, 1'b0, 24'h0);
      chk("queue_drained", 64'(expq.size()), 64'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vip_target_box_overlay.md
Name: vip_target_box_overlay

Overview:
- Consumes the two 43-bit target boxes produced by the multi-target detector and draws their rectangle borders onto the live RGB video stream ahead of the HDMI 720P output.
- Box format (shared): {flag[42], ymax[41:32], xmax[31:21], ymin[20:11], xmin[10:0]}.
- Boxes are shadowed at frame start, so a frame is never drawn with boxes that change mid-frame.
- Video timing passes through with fixed latency.

Parameters:
- IMG_HDISP, 11'd1280: active pixels per line.
- IMG_VDISP, 10'd720: active lines per frame.
- DATA_W, 24: pixel width (RGB888).
- BOX_THICK, 2: border thickness in pixels, 1..15.
- COLOR1, 24'hFF0000: border colour for box 1.
- COLOR2, 24'h00FF00: border colour for box 2.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  async active-low reset
- per_frame_vsync  in  1  frame valid, high during frame
- per_frame_href  in  1  line valid
- per_frame_clken  in  1  pixel strobe
- per_img_data  in  DATA_W  input pixel
- target_pos_in1  in  43  box 1, detector format
- target_pos_in2  in  43  box 2, detector format
- overlay_en  in  1  0 = transparent pass-through
- post_frame_vsync  out  1  delayed vsync
- post_frame_href  out  1  delayed href
- post_frame_clken  out  1  delayed clken
- post_img_data  out  DATA_W  overlaid pixel

Behaviour:
- Reset and clocking:
  - Single clock domain.
  - Reset is asynchronous and active-low, on rst_n.
  - Reset values: all post_* outputs 0; shadow boxes 0 (flag clear); counters 0.
- Timing pass-through:
  - Fixed 2-cycle latency, for every cycle, on vsync, href, clken and data alike.
  - No stalls and no back-pressure.
- Shadow registers:
  - On the vsync rising edge (vsync=1, previous=0), load box_sh1/2 <= target_pos_in1/2.
  - Otherwise hold.
  - The detector updates its outputs on the vsync falling edge, so the shadows always contain the previous frame's result.
- Counters (stage 1):
  - x_cnt: 11 bit, +1 on each clken while href=1; cleared when href=0; saturates at 2047.
  - y_cnt: 10 bit, +1 on each href falling edge; saturates at 1023.
  - Both cleared while vsync=0.
  - The coordinate of the current pixel is the count value before increment.
- Border test (stage 2), per box i:
  - hit_i = flag & (xmin<=x<=xmax) & (ymin<=y<=ymax) & (x < xmin+T | x+T > xmax | y < ymin+T | y+T > ymax).
  - All sums are computed at 12 bits; no subtraction is used, so there is no underflow.
- Degenerate and edge cases:
  - A box with xmin>xmax or ymin>ymax draws nothing.
  - A box with width or height <= 2T renders fully filled.
  - Box coordinates beyond the image simply never match.
- Colour selection:
  - hit1 → COLOR1; else hit2 → COLOR2; else the input pixel. Box 1 has priority where boxes overlap.
  - Pixels with clken=0 at stage 2 are output unmodified.
  - overlay_en=0 forces pass-through.
- overlay_en timing:
  - overlay_en is sampled per pixel, with no frame shadowing.
  - A mid-frame toggle takes effect 2 cycles later.
- Mid-frame reset: all outputs go to 0 immediately; the next full frame draws nothing until a vsync rising edge loads the shadows.
- Missing vsync rising edge (vsync stuck high): the shadows retain their old boxes.

Optional Feature:
- Macro: VIP_BOX_CROSSHAIR_EN.
- When defined, each valid box also draws a 1-pixel crosshair through its centre: cx=(xmin+xmax)>>1, cy=(ymin+ymax)>>1.
  - Hit when (x==cx & ymin<=y<=ymax) | (y==cy & xmin<=x<=xmax), in the same box colour and with the same priority.
  - cx and cy are computed once per frame at the shadow load, in one extra register stage that completes before the first active line. Pixel latency stays 2.
- When undefined: no crosshair logic; borders only.

Decomposition:
- Package vip_box_pkg holds:
  - Bit-field constants: BOX_FLAG=42, YMAX 41:32, XMAX 31:21, YMIN 20:11, XMIN 10:0.
  - BOX_W=43.
  - A packed struct for the box format.
  - Default colours.
- Sub-module vip_box_hit (combinational plus output register): takes one shadow box, x, y and T; produces hit, and hit_cross under the macro. It is instantiated twice.

Test Plan:
- Pass-through: overlay_en=0, 1280x720 ramp → post_img_data equals input delayed exactly 2 clk; syncs delayed 2.
- Single box: box1={1,y100..120,x200..260}, T=2 → pixels (200,110), (201,110), (259,100), (230,119) are FF0000; (202,110) and (230,102) unchanged; box2 flag=0 → no green anywhere.
- Overlap priority: box1 x10..50/y10..50, box2 x40..90/y40..90 → (50,45) red; (90,60) green; counts of red and green pixels match the golden model.
- Frame shadowing: change target_pos_in1 at line 300 of frame N → frame N unchanged throughout; frame N+1 shows the new box.
- Degenerate/edge: box xmin=1279,xmax=1279,ymin=0,ymax=719 → one full-height red column at x=1279; box xmin=300,xmax=200 → nothing drawn.
- Reset mid-frame: assert rst_n low at pixel (640,360) → all post_* 0 asynchronously; the following frame is pass-through until a vsync rising edge, then boxes appear.
